// File: rtl/minirisc_pkg.sv
// minirisc_pkg -- shared definitions for the tt_um_minirisc accumulator core.
//   DATA_W / NUM_REGS  : datapath width and register-file depth
//   *_LSB/_MSB/_BIT    : field positions inside the ui_in instruction byte
//   opcode_t           : instruction opcodes (codes 10-15 decode as NOP)
//   writes_acc()       : true for opcodes that update acc (and therefore Z)
package minirisc_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NUM_REGS = 4;
   localparam int unsigned REG_AW   = $clog2(NUM_REGS);

   localparam int unsigned OP_LSB   = 0;
   localparam int unsigned OP_MSB   = 3;
   localparam int unsigned ADDR_LSB = 4;
   localparam int unsigned ADDR_MSB = 5;
   localparam int unsigned RSVD_BIT = 6;
   localparam int unsigned OSEL_BIT = 7;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_LOAD  = 4'd1,
      OP_ADD   = 4'd2,
      OP_SUB   = 4'd3,
      OP_STORE = 4'd4,
      OP_LDR   = 4'd5,
      OP_AND   = 4'd6,
      OP_OR    = 4'd7,
      OP_XOR   = 4'd8,
      OP_CLR   = 4'd9
   } opcode_t;

   function automatic logic writes_acc(input opcode_t op);
      case (op)
         OP_LOAD, OP_ADD, OP_SUB, OP_LDR,
         OP_AND, OP_OR, OP_XOR, OP_CLR: writes_acc = 1'b1;
         default:                       writes_acc = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/minirisc_alu.sv
// minirisc_alu -- combinational ALU for the minirisc core.
//   op       : decoded opcode
//   acc      : current accumulator
//   imm      : operand (immediate, or register data for LDR)
//   carry_in : current carry flag, passed through when op leaves C alone
//   result   : next accumulator value (equals acc for non-writing ops)
//   carry    : next carry flag
//   zero     : result == 0 (only meaningful when the op writes acc)
module minirisc_alu
   import minirisc_pkg::*;
(
   input  opcode_t           op,
   input  logic [DATA_W-1:0] acc,
   input  logic [DATA_W-1:0] imm,
   input  logic              carry_in,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              zero
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // Borrow appears as the extra top bit of the widened subtraction.
   assign sum  = {1'b0, acc} + {1'b0, imm};
   assign diff = {1'b0, acc} - {1'b0, imm};

   always_comb begin
      result = acc;
      carry  = carry_in;
      case (op)
         OP_LOAD: result = imm;
         OP_ADD:  {carry, result} = sum;
         OP_SUB:  {carry, result} = diff;
         OP_LDR:  result = imm;
         OP_AND:  result = acc & imm;
         OP_OR:   result = acc | imm;
         OP_XOR:  result = acc ^ imm;
         OP_CLR: begin
            result = '0;
            carry  = 1'b0;
         end
         default: ;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/tt_um_minirisc.sv
// tt_um_minirisc -- accumulator RISC core in TinyTapeout wrapper form.
// One instruction per enabled clock; the host streams instructions.
//   clk     : clock, all state on rising edge
//   rst     : synchronous reset, active-high (acc=0, regs=0, C=0, Z=1)
//   ena     : execute enable, 0 holds all state
//   ui_in   : instruction [3:0] opcode, [5:4] reg addr, [6] reserved, [7] output select
//   uio_in  : immediate operand
//   uo_out  : accumulator (or status view, see below)
//   uio_out : constant zero
//   uio_oe  : constant zero (uio bank is input-only)
// Optional build macro MINIRISC_STATUS_EN: when defined, ui_in[7]=1 shows
// {C, Z, acc[7], 3'b000, addr} on uo_out instead of acc.
module tt_um_minirisc
   import minirisc_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   opcode_t            op;
   logic [REG_AW-1:0]  addr;
   logic [DATA_W-1:0]  acc;
   logic [DATA_W-1:0]  regs [NUM_REGS];
   logic               carry_flag;
   logic               zero_flag;
   logic [DATA_W-1:0]  operand;
   logic [DATA_W-1:0]  alu_result;
   logic               alu_carry;
   logic               alu_zero;

   assign op   = opcode_t'(ui_in[OP_MSB:OP_LSB]);
   assign addr = ui_in[ADDR_MSB:ADDR_LSB];

   // LDR reuses the ALU's pass-through path with register data as operand.
   assign operand = (op == OP_LDR) ? regs[addr] : uio_in;

   minirisc_alu u_alu (
      .op       (op),
      .acc      (acc),
      .imm      (operand),
      .carry_in (carry_flag),
      .result   (alu_result),
      .carry    (alu_carry),
      .zero     (alu_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         carry_flag <= 1'b0;
         zero_flag  <= 1'b1;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (ena) begin
         carry_flag <= alu_carry;
         if (op == OP_STORE) begin
            regs[addr] <= acc;
         end
         if (writes_acc(op)) begin
            acc       <= alu_result;
            zero_flag <= alu_zero;
         end
      end
   end

`ifdef MINIRISC_STATUS_EN
   logic unused_ui;
   assign unused_ui = ui_in[RSVD_BIT];
   assign uo_out = ui_in[OSEL_BIT] ? {carry_flag, zero_flag, acc[DATA_W-1], 3'b000, addr}
                                   : acc;
`else
   logic unused_ui;
   assign unused_ui = ^{ui_in[OSEL_BIT], ui_in[RSVD_BIT]};
   assign uo_out = acc;
`endif

   assign uio_out = '0;
   assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_minirisc.sv
// tb_tt_um_minirisc -- directed plus randomized bench for tt_um_minirisc,
// checked against an arithmetic reference model of the instruction set.
module tb_tt_um_minirisc;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int tests = 0;
   int fails = 0;

   // Reference state
   int m_acc;
   int m_c;
   int m_z;
   int m_regs [4];

   tt_um_minirisc dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] ins(input int op, input int a, input int osel);
      logic [7:0] v;
      v = 8'h00;
      v[3:0] = 4'(op);
      v[5:4] = 2'(a);
      v[7]   = 1'(osel);
      return v;
   endfunction

   function automatic void model_step(input logic r, input logic e,
                                      input logic [7:0] ui, input logic [7:0] im);
      int op, a, imm, s;
      op  = int'(ui[3:0]);
      a   = int'(ui[5:4]);
      imm = int'(im);
      if (r) begin
         m_acc = 0; m_c = 0; m_z = 1;
         for (int i = 0; i < 4; i++) m_regs[i] = 0;
         return;
      end
      if (!e) return;
      case (op)
         1: m_acc = imm;
         2: begin s = m_acc + imm; m_c = (s > 255) ? 1 : 0; m_acc = s % 256; end
         3: begin m_c = (imm > m_acc) ? 1 : 0; m_acc = (m_acc - imm + 256) % 256; end
         4: m_regs[a] = m_acc;
         5: m_acc = m_regs[a];
         6: m_acc = m_acc & imm;
         7: m_acc = m_acc | imm;
         8: m_acc = m_acc ^ imm;
         9: begin m_acc = 0; m_c = 0; end
         default: ;
      endcase
      if (op >= 1 && op <= 9 && op != 4) m_z = (m_acc == 0) ? 1 : 0;
   endfunction

   function automatic logic [7:0] exp_out();
`ifdef MINIRISC_STATUS_EN
      if (ui_in[7]) return {m_c[0], m_z[0], m_acc[7], 3'b000, ui_in[5:4]};
`endif
      return m_acc[7:0];
   endfunction

   task automatic check8(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
      end
   endtask

   // Drive at negedge, model at posedge, sample 1 time unit later.
   task automatic cycle(input logic r, input logic e, input logic [7:0] ui,
                        input logic [7:0] im, input string tag);
      @(negedge clk);
      rst = r; ena = e; ui_in = ui; uio_in = im;
      @(posedge clk);
      model_step(r, e, ui, im);
      #1;
      check8({tag, " out"}, uo_out, exp_out());
      check8({tag, " C"}, {7'b0, dut.carry_flag}, 8'(m_c));
      check8({tag, " Z"}, {7'b0, dut.zero_flag}, 8'(m_z));
      check8({tag, " uio_out"}, uio_out, 8'h00);
      check8({tag, " uio_oe"}, uio_oe, 8'h00);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;

      // Reset
      cycle(1, 1, 8'h00, 8'h00, "rst0");
      cycle(1, 1, 8'h00, 8'h00, "rst1");
      check8("rst acc", uo_out, 8'h00);
      check8("rst Z", {7'b0, dut.zero_flag}, 8'h01);
`ifdef MINIRISC_STATUS_EN
      cycle(0, 1, ins(0, 0, 1), 8'h00, "stat_rst");
      check8("stat_rst view", uo_out, 8'h40);
`endif

      // Basic sequence
      cycle(0, 1, ins(1, 0, 0), 8'h05, "load5");  check8("load5 c", uo_out, 8'h05);
      cycle(0, 1, ins(2, 0, 0), 8'h03, "add3");   check8("add3 c", uo_out, 8'h08);
      cycle(0, 1, ins(3, 0, 0), 8'h02, "sub2");   check8("sub2 c", uo_out, 8'h06);
      cycle(0, 1, ins(4, 1, 0), 8'h77, "st1");    check8("st1 c", uo_out, 8'h06);
      cycle(0, 1, ins(0, 0, 0), 8'h99, "idle");   check8("idle c", uo_out, 8'h06);
      cycle(0, 1, ins(9, 0, 0), 8'h00, "clr");    check8("clr c", uo_out, 8'h00);
      cycle(0, 1, ins(5, 1, 0), 8'h00, "ldr1");   check8("ldr1 c", uo_out, 8'h06);

      // Carry / borrow boundaries
      cycle(0, 1, ins(1, 0, 0), 8'hFF, "loadFF");
      cycle(0, 1, ins(2, 0, 0), 8'h01, "addwrap");
      check8("addwrap acc", uo_out, 8'h00);
      check8("addwrap C", {7'b0, dut.carry_flag}, 8'h01);
      check8("addwrap Z", {7'b0, dut.zero_flag}, 8'h01);
      cycle(0, 1, ins(3, 0, 0), 8'h01, "borrow");
      check8("borrow acc", uo_out, 8'hFF);
      check8("borrow C", {7'b0, dut.carry_flag}, 8'h01);

      // Enable gating
      cycle(0, 1, ins(1, 0, 0), 8'h20, "load20");
      for (int i = 0; i < 3; i++) cycle(0, 0, ins(2, 0, 0), 8'h10, "hold");
      check8("hold c", uo_out, 8'h20);
      cycle(0, 1, ins(2, 0, 0), 8'h10, "resume"); check8("resume c", uo_out, 8'h30);

      // Reset wins over a coincident instruction and clears regs
      cycle(0, 1, ins(1, 0, 0), 8'h42, "load42");
      cycle(0, 1, ins(4, 3, 0), 8'h00, "st3");
      cycle(1, 1, ins(2, 0, 0), 8'h01, "rstadd"); check8("rstadd c", uo_out, 8'h00);
      for (int a = 0; a < 4; a++) begin
         cycle(0, 1, ins(5, a, 0), 8'h00, "ldr_clr");
         check8("ldr_clr c", uo_out, 8'h00);
      end

`ifdef MINIRISC_STATUS_EN
      cycle(0, 1, ins(1, 0, 0), 8'h80, "load80");
      cycle(0, 1, ins(0, 0, 1), 8'h00, "stat80"); check8("stat80 c", uo_out, 8'h20);
      cycle(0, 1, ins(0, 0, 0), 8'h00, "acc80");  check8("acc80 c", uo_out, 8'h80);
`endif

      // Randomized stream
      for (int i = 0; i < 400; i++) begin
         logic r, e;
         r = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 7) != 0);
         cycle(r, e, 8'($urandom), 8'($urandom), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
